// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the instruction-fetch
// port and the data port. Round-robin on contention, one access per cycle, bounds
// check with error response, optional zero-fill sweep after reset.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  fetch_rvalid,
    output logic [31:0]           fetch_rdata,
    output logic                  fetch_err,
    input  logic                  data_valid,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [31:0]           data_wdata,
    input  logic [3:0]            data_wmask,
    output logic                  data_ready,
    output logic                  data_rvalid,
    output logic [31:0]           data_rdata,
    output logic                  data_err,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  init_done
);

    // One extra bit so MEM_WORDS == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_WORDS - 1);

    typedef enum logic { ST_INIT, ST_RUN } state_t;
    typedef enum logic { PORT_FETCH, PORT_DATA } port_t;

    state_t                state;
    port_t                 rr_last;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  init_done_q;

    // Response pipeline: one slot per port, filled on acceptance, drained next cycle.
    logic                  fetch_pend;
    logic                  fetch_pend_err;
    logic                  data_pend;
    logic                  data_pend_err;
    logic                  data_pend_rd;

    logic                  gnt_fetch;
    logic                  gnt_data;
    logic                  fetch_in_range;
    logic                  data_in_range;

    assign fetch_in_range = ({1'b0, fetch_addr} < ADDR_LIMIT);
    assign data_in_range  = ({1'b0, data_addr} < ADDR_LIMIT);

    // Grant: single requester wins outright; on contention the port not served last wins.
    always_comb begin
        gnt_fetch = 1'b0;
        gnt_data  = 1'b0;
        if (!reset && state == ST_RUN) begin
            if (fetch_valid && data_valid) begin
                if (rr_last == PORT_FETCH) begin
                    gnt_data = 1'b1;
                end else begin
                    gnt_fetch = 1'b1;
                end
            end else begin
                gnt_fetch = fetch_valid;
                gnt_data  = data_valid;
            end
        end
    end

    assign fetch_ready = gnt_fetch;
    assign data_ready  = gnt_data;

    // RAM drive: zero-fill sweep in INIT, otherwise the granted in-range request.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (!reset && state == ST_INIT) begin
            mem_en   = 1'b1;
            mem_we   = 4'hF;
            mem_addr = clr_cnt;
        end else if (gnt_fetch) begin
            mem_en    = fetch_in_range;
            mem_addr  = fetch_addr;
            mem_wdata = data_wdata;
        end else if (gnt_data) begin
            mem_en    = data_in_range;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            mem_we    = (data_in_range && data_we) ? data_wmask : 4'h0;
        end
    end

    // Sequencer state, clear counter, round-robin pointer and response slots.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
            clr_cnt        <= '0;
            rr_last        <= PORT_FETCH;
            init_done_q    <= 1'b0;
            fetch_pend     <= 1'b0;
            fetch_pend_err <= 1'b0;
            data_pend      <= 1'b0;
            data_pend_err  <= 1'b0;
            data_pend_rd   <= 1'b0;
        end else begin
            fetch_pend     <= gnt_fetch;
            fetch_pend_err <= gnt_fetch && !fetch_in_range;
            data_pend      <= gnt_data;
            data_pend_err  <= gnt_data && !data_in_range;
            data_pend_rd   <= gnt_data && data_in_range && !data_we;
            if (gnt_fetch) begin
                rr_last <= PORT_FETCH;
            end else if (gnt_data) begin
                rr_last <= PORT_DATA;
            end
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (clr_cnt == LAST_ADDR) begin
                        state       <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    init_done_q <= 1'b1;
                end
            endcase
        end
    end

    // Responses are masked while reset is held so a pending one is dropped, not delivered.
    assign fetch_rvalid = fetch_pend && !reset;
    assign fetch_err    = fetch_pend_err && !reset;
    assign fetch_rdata  = (fetch_pend && !fetch_pend_err && !reset) ? mem_rdata : 32'h0;
    assign data_rvalid  = data_pend && !reset;
    assign data_err     = data_pend_err && !reset;
    assign data_rdata   = (data_pend_rd && !reset) ? mem_rdata : 32'h0;
    assign init_done    = init_done_q && !reset;

endmodule
